// File: rtl/ram_based_fifo_result_packer_pkg.sv
// rtl/ram_based_fifo_result_packer_pkg.sv - shared widths, thresholds and lane helper for the result packer
package ram_based_fifo_result_packer_pkg;

  localparam int DATA_W                 = 16;
  localparam int DATA_R                 = 128;
  localparam int RATIO                  = DATA_R / DATA_W;
  localparam int DEPTH_R                = 8;
  localparam int ALMOST_FULL_THRESHOLD  = 240;
  localparam int ALMOST_EMPTY_THRESHOLD = 2;

  typedef logic [DATA_W-1:0]  narrow_t;
  typedef logic [DATA_R-1:0]  wide_t;
  typedef logic [DEPTH_R-1:0] ptr_t;
  typedef logic [DEPTH_R:0]   cnt_t;
  typedef logic [2:0]         lane_t;

  // Returns w with lane l replaced by d; other lanes untouched.
  function automatic wide_t place_lane(input wide_t w, input lane_t l, input narrow_t d);
    wide_t r;
    r = w;
    for (int k = 0; k < RATIO; k++) begin
      if (lane_t'(k) == l) r[k*DATA_W +: DATA_W] = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_based_fifo_result_packer_ram.sv
// rtl/ram_based_fifo_result_packer_ram.sv - dual-port wide-word RAM with registered, held read data
module ram_based_fifo_result_packer_ram
  import ram_based_fifo_result_packer_pkg::*;
(
  input  logic              system_clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [DEPTH_R-1:0] i_wr_addr,
  input  logic [DATA_R-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [DEPTH_R-1:0] i_rd_addr,
  output logic [DATA_R-1:0] o_rd_data
);

  logic [DATA_R-1:0] mem [0:(1<<DEPTH_R)-1];
  logic [DATA_R-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge system_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
  end

  // Output register only loads on a read, so data is held between reads.
  always_comb begin
    rd_data_d = rd_data_q;
    if (i_rd_en) rd_data_d = mem[i_rd_addr];
  end

  always_ff @(posedge system_clk) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/ram_based_fifo_result_packer.sv
// rtl/ram_based_fifo_result_packer.sv - packs 16-bit results into 128-bit words stored in a RAM FIFO
module ram_based_fifo_result_packer
  import ram_based_fifo_result_packer_pkg::*;
(
  input  logic               system_clk,
  input  logic               rst_n,
  input  logic               i_wren,
  input  logic [DATA_W-1:0]  i_wrdata,
  input  logic               i_flush,
  output logic               o_full,
  output logic               o_almost_full,
  input  logic               i_rden,
  output logic [DATA_R-1:0]  o_rddata,
  output logic               o_rddata_valid,
  output logic               o_empty,
  output logic               o_almost_empty,
  output logic [DEPTH_R:0]   o_word_cnt,
  output logic [2:0]         o_lane_cnt
);

  ptr_t  wrptr_q, wrptr_d;
  ptr_t  rdptr_q, rdptr_d;
  cnt_t  word_cnt_q, word_cnt_d;
  lane_t lane_cnt_q, lane_cnt_d;
  wide_t asm_q, asm_d;
  logic  rddata_valid_q, rddata_valid_d;

  logic  full, empty, wren, rden, commit_full, commit_flush, commit;
  wide_t asm_merged;
  logic [3:0] lane_fill;

  assign full  = (word_cnt_q == cnt_t'(1 << DEPTH_R));
  assign empty = (word_cnt_q == '0);

  always_comb begin
    wren       = i_wren & ~full;
    rden       = i_rden & ~empty;
    asm_merged = wren ? place_lane(asm_q, lane_cnt_q, i_wrdata) : asm_q;
    lane_fill  = wren ? ({1'b0, lane_cnt_q} + 4'd1) : {1'b0, lane_cnt_q};
    commit_full  = wren && (lane_cnt_q == 3'd7);
    // Lanes above lane_cnt are always zero in asm_q, so a flush commit is already zero-padded.
    commit_flush = i_flush && !full && !commit_full && (lane_fill != 4'd0);
    commit       = commit_full | commit_flush;

    lane_cnt_d     = commit ? '0 : lane_fill[2:0];
    asm_d          = commit ? '0 : asm_merged;
    wrptr_d        = wrptr_q + ptr_t'(commit);
    rdptr_d        = rdptr_q + ptr_t'(rden);
    word_cnt_d     = word_cnt_q + cnt_t'(commit) - cnt_t'(rden);
    rddata_valid_d = rden;
  end

  always_ff @(posedge system_clk) begin
    if (!rst_n) begin
      wrptr_q        <= '0;
      rdptr_q        <= '0;
      word_cnt_q     <= '0;
      lane_cnt_q     <= '0;
      asm_q          <= '0;
      rddata_valid_q <= 1'b0;
    end else begin
      wrptr_q        <= wrptr_d;
      rdptr_q        <= rdptr_d;
      word_cnt_q     <= word_cnt_d;
      lane_cnt_q     <= lane_cnt_d;
      asm_q          <= asm_d;
      rddata_valid_q <= rddata_valid_d;
    end
  end

  ram_based_fifo_result_packer_ram u_ram (
    .system_clk (system_clk),
    .rst_n      (rst_n),
    .i_wr_en    (commit),
    .i_wr_addr  (wrptr_q),
    .i_wr_data  (asm_merged),
    .i_rd_en    (rden),
    .i_rd_addr  (rdptr_q),
    .o_rd_data  (o_rddata)
  );

  assign o_full         = full;
  assign o_empty        = empty;
  assign o_almost_full  = (word_cnt_q >= cnt_t'(ALMOST_FULL_THRESHOLD));
  assign o_almost_empty = (word_cnt_q <  cnt_t'(ALMOST_EMPTY_THRESHOLD));
  assign o_rddata_valid = rddata_valid_q;
  assign o_word_cnt     = word_cnt_q;
  assign o_lane_cnt     = lane_cnt_q;

endmodule

// File: tb/tb_ram_based_fifo_result_packer.sv
// tb/tb_ram_based_fifo_result_packer.sv - directed self-checking bench for the result packer FIFO
module tb_ram_based_fifo_result_packer;

  logic         system_clk = 1'b0;
  logic         rst_n;
  logic         i_wren;
  logic [15:0]  i_wrdata;
  logic         i_flush;
  logic         i_rden;
  logic         o_full, o_almost_full, o_rddata_valid, o_empty, o_almost_empty;
  logic [127:0] o_rddata;
  logic [8:0]   o_word_cnt;
  logic [2:0]   o_lane_cnt;

  int checks   = 0;
  int failures = 0;

  ram_based_fifo_result_packer dut (
    .system_clk     (system_clk),
    .rst_n          (rst_n),
    .i_wren         (i_wren),
    .i_wrdata       (i_wrdata),
    .i_flush        (i_flush),
    .o_full         (o_full),
    .o_almost_full  (o_almost_full),
    .i_rden         (i_rden),
    .o_rddata       (o_rddata),
    .o_rddata_valid (o_rddata_valid),
    .o_empty        (o_empty),
    .o_almost_empty (o_almost_empty),
    .o_word_cnt     (o_word_cnt),
    .o_lane_cnt     (o_lane_cnt)
  );

  always #5 system_clk = ~system_clk;

  task automatic tick;
    @(posedge system_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [15:0] base);
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[k*16 +: 16] = base + 16'(k);
    return r;
  endfunction

  task automatic do_reset;
    rst_n = 1'b0; i_wren = 1'b0; i_flush = 1'b0; i_rden = 1'b0; i_wrdata = '0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic write1(input logic [15:0] d);
    i_wren = 1'b1; i_wrdata = d;
    tick;
    i_wren = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"},    128'(o_empty), 128'(1));
    chk({tag, "_aempty"},   128'(o_almost_empty), 128'(1));
    chk({tag, "_full"},     128'(o_full), 128'(0));
    chk({tag, "_afull"},    128'(o_almost_full), 128'(0));
    chk({tag, "_wcnt"},     128'(o_word_cnt), 128'(0));
    chk({tag, "_lcnt"},     128'(o_lane_cnt), 128'(0));
    chk({tag, "_rddata"},   o_rddata, 128'(0));
    chk({tag, "_rdvalid"},  128'(o_rddata_valid), 128'(0));
  endtask

  initial begin
    int sent;
    int rd;
    int cyc;

    do_reset;
    chk_reset_state("reset");

    // Eight writes form one word; empty drops only after the 8th.
    for (int i = 1; i <= 8; i++) begin
      write1(16'(i));
      if (i == 7) chk("empty_after7", 128'(o_empty), 128'(1));
    end
    chk("empty_after8", 128'(o_empty), 128'(0));
    chk("wcnt_after8", 128'(o_word_cnt), 128'(1));
    i_rden = 1'b1; tick; i_rden = 1'b0;
    chk("first_word", o_rddata, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk("first_valid", 128'(o_rddata_valid), 128'(1));
    tick;
    chk("valid_pulse", 128'(o_rddata_valid), 128'(0));
    chk("rddata_held", o_rddata, 128'h0008_0007_0006_0005_0004_0003_0002_0001);

    // Flush of a partial word, flush at lane 0, flush with a same-cycle write.
    write1(16'h000A); write1(16'h000B); write1(16'h000C);
    chk("lane_3", 128'(o_lane_cnt), 128'(3));
    i_flush = 1'b1; tick; i_flush = 1'b0;
    chk("flush_lane", 128'(o_lane_cnt), 128'(0));
    chk("flush_wcnt", 128'(o_word_cnt), 128'(1));
    i_flush = 1'b1; tick; i_flush = 1'b0;
    chk("flush_noop", 128'(o_word_cnt), 128'(1));
    write1(16'h0011);
    i_flush = 1'b1; write1(16'h0022); i_flush = 1'b0;
    chk("flush_wr_wcnt", 128'(o_word_cnt), 128'(2));
    for (int i = 0; i < 7; i++) write1(16'h0031 + 16'(i));
    i_flush = 1'b1; write1(16'h0038); i_flush = 1'b0;
    chk("flush_full_wcnt", 128'(o_word_cnt), 128'(3));
    chk("flush_full_lane", 128'(o_lane_cnt), 128'(0));
    i_rden = 1'b1;
    tick; chk("flush_word", o_rddata, 128'h000C_000B_000A);
    tick; chk("flush_wr_word", o_rddata, 128'h0022_0011);
    tick; chk("flush_noop_word", o_rddata, mk(16'h0031));
    i_rden = 1'b0;
    chk("drained", 128'(o_empty), 128'(1));

    // Fill to full, check thresholds, then a dropped write.
    do_reset;
    i_wren = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      i_wrdata = 16'(i);
      tick;
      chk("fill_afull", 128'(o_almost_full), 128'(((i + 1) / 8) >= 240));
      chk("fill_aempty", 128'(o_almost_empty), 128'(((i + 1) / 8) < 2));
    end
    chk("full_set", 128'(o_full), 128'(1));
    i_wrdata = 16'hFFFF; i_flush = 1'b1;
    tick;
    i_wren = 1'b0; i_flush = 1'b0;
    chk("drop_wcnt", 128'(o_word_cnt), 128'(256));
    chk("drop_lane", 128'(o_lane_cnt), 128'(0));
    i_rden = 1'b1;
    for (int w = 0; w < 256; w++) begin
      tick;
      chk("full_contents", o_rddata, mk(16'(w * 8)));
    end
    i_rden = 1'b0;
    chk("full_drained", 128'(o_empty), 128'(1));

    // Commit and read in the same cycle at word_cnt 5.
    do_reset;
    for (int i = 0; i < 47; i++) write1(16'h1000 + 16'(i));
    chk("cr_pre_wcnt", 128'(o_word_cnt), 128'(5));
    chk("cr_pre_lane", 128'(o_lane_cnt), 128'(7));
    i_wren = 1'b1; i_wrdata = 16'h1000 + 16'd47; i_rden = 1'b1;
    tick;
    i_wren = 1'b0; i_rden = 1'b0;
    chk("cr_wcnt", 128'(o_word_cnt), 128'(5));
    chk("cr_data", o_rddata, mk(16'h1000));

    // Stream 300 words with random read gaps across pointer wrap.
    do_reset;
    sent = 0; rd = 0; cyc = 0;
    while (rd < 300 && cyc < 20000) begin
      i_wren   = (sent < 2400);
      i_wrdata = 16'h4000 + 16'(sent);
      i_rden   = ($urandom_range(0, 2) != 0);
      tick;
      if (i_wren) sent++;
      if (o_rddata_valid) begin
        chk("stream_word", o_rddata, mk(16'h4000 + 16'(rd * 8)));
        rd++;
      end
      cyc++;
    end
    i_wren = 1'b0; i_rden = 1'b0;
    chk("stream_count", 128'(rd), 128'(300));
    chk("stream_wcnt", 128'(o_word_cnt), 128'(0));

    // Reset with stored and partial data.
    do_reset;
    for (int i = 0; i < 84; i++) write1(16'h2000 + 16'(i));
    chk("pre_rst_wcnt", 128'(o_word_cnt), 128'(10));
    chk("pre_rst_lane", 128'(o_lane_cnt), 128'(4));
    rst_n = 1'b0; tick; rst_n = 1'b1;
    chk_reset_state("midrst");
    for (int i = 0; i < 8; i++) write1(16'h3000 + 16'(i));
    chk("post_rst_wcnt", 128'(o_word_cnt), 128'(1));
    chk("post_rst_lane", 128'(o_lane_cnt), 128'(0));
    i_rden = 1'b1; tick; i_rden = 1'b0;
    chk("post_rst_word", o_rddata, mk(16'h3000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_based_fifo_result_packer.md
# ram_based_fifo_result_packer

Narrow-to-wide packing FIFO for the result/writeback path. It accepts 16-bit result words from the compute array and gathers every 8 consecutive words into one 128-bit word in an on-chip RAM. The DDR write-back engine drains these wide words. It is the write-direction counterpart of the wide-to-narrow bias buffer FIFO, and a flush input commits a partial word zero-padded.

## Interface
- DATA_W, 16, narrow write width
- DATA_R, 128, wide read width
- RATIO, DATA_R/DATA_W = 8, lanes per wide word
- DEPTH_R, 8, log2 of wide-word capacity (256 words)
- ALMOST_FULL_THRESHOLD, 240, wide-word count at which o_almost_full asserts
- ALMOST_EMPTY_THRESHOLD, 2, wide-word count below which o_almost_empty asserts

Ports:
- system_clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- i_wren  in  1  narrow write request
- i_wrdata  in  DATA_W  narrow write data
- i_flush  in  1  commit current partial word, zero-padded
- o_full  out  1  RAM holds 2**DEPTH_R wide words
- o_almost_full  out  1  word count >= ALMOST_FULL_THRESHOLD
- i_rden  in  1  wide read request
- o_rddata  out  DATA_R  wide read data, held until the next read
- o_rddata_valid  out  1  one-cycle pulse when o_rddata updates
- o_empty  out  1  no committed wide words
- o_almost_empty  out  1  word count < ALMOST_EMPTY_THRESHOLD
- o_word_cnt  out  DEPTH_R+1  committed wide words, 0..256
- o_lane_cnt  out  3  lanes filled in the assembly register

## Operation
- Write acceptance: wren = i_wren & !o_full. When o_full is high, a write is dropped, even if a read occurs in the same cycle.
- Lane placement: lane k sits at bits [16k+15:16k]. The first accepted word goes to [15:0].
- Packing:
  - Each accepted write stores its data in the lane given by lane_cnt, then increments lane_cnt.
  - On the 8th lane (lane_cnt==7), the combinational word {i_wrdata, asm[111:0]} is written to RAM at wrptr in the same cycle.
  - On that commit, lane_cnt returns to 0, wrptr increments, and word_cnt increments.
- Flush:
  - If i_flush is high and lane_cnt (after any same-cycle write) is 1..7, commit {zeros, filled lanes} and set lane_cnt to 0.
  - If that lane_cnt is 0, flush is a no-op.
  - If a same-cycle write completes a word, the flush is also a no-op.
  - Flush while o_full is high is ignored and the partial word is retained.
- Read:
  - rden = i_rden & !o_empty.
  - The RAM is read at rdptr. rdptr increments and word_cnt decrements.
- Counting: a commit and a read in the same cycle leave word_cnt unchanged.
- Pointers: wrptr and rdptr are DEPTH_R bits and wrap 255→0 naturally.
- Status decode: o_full = word_cnt==256; o_empty = word_cnt==0. Thresholds compare against the registered word_cnt.
- No read/write address collision is possible: reads only address words committed on an earlier edge.
- RAM selection: when `device == "simulation"`, use simulation_ram with DATA_W=DATA_R=128 and DEPTH_W=DEPTH_R=8. Otherwise use vendor result_ram.

## Timing
- Reset values:
  - wrptr, rdptr, word_cnt, lane_cnt and the assembly register are 0.
  - o_rddata is 0 and o_rddata_valid is 0.
  - o_empty=1, o_almost_empty=1, o_full=0, o_almost_full=0.
- Reset mid-operation discards all stored and partial data.
- Read latency: a read accepted in cycle N gives o_rddata and o_rddata_valid=1 in cycle N+1.
- Commit-to-read: a commit in cycle N drops o_empty in N+1. The earliest read is in N+1, with data in N+2.
- Status outputs are functions of registered state only. There is no combinational path from i_rden or i_wren to o_full or o_empty.
- Back-to-back reads, one per cycle, are supported until empty.

## Structure
- Shared `parameters.v` provides `device` and RESULT_RATIO.
- One sub-module: the dual-port word RAM (simulation_ram / result_ram).
- Packing, counters and status logic stay in this module.

## Test plan
- Reset, then write 0x0001..0x0008 → o_empty low one cycle after the 8th write. Read → o_rddata=0x0008_0007_0006_0005_0004_0003_0002_0001 with o_rddata_valid one cycle later.
- Write 0x000A, 0x000B, 0x000C, then i_flush → committed word 0x0000_…_000C_000B_000A. lane_cnt=0 and word_cnt=1.
- 2048 writes with no reads → o_almost_full at word 240 and o_full after the 2048th write. The 2049th write is dropped and the contents are unchanged.
- At word_cnt=5, a commit and a read in the same cycle → word_cnt stays 5, and the data returned is the oldest word.
- Stream 300 wide words with random read gaps → all words are read in order across pointer wrap, with no loss or duplication.
- Reset at lane_cnt=4 with 10 words stored → all reset values hold. The next 8 writes form one clean word and word_cnt=1.
